dir_offset_encoder: RTL and testbench

//  Inverse of the direction-offset distributed ROM: streams signed 5-bit direction offsets
//  (+8..-7) and re-encodes each into its 4-bit orientation bin and 8-bit table address.

---
 rtl/dir_offset_encoder.sv | 125 ++++++++++++
 tb/tb_dir_offset_encoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dir_offset_encoder.sv
// Re-encodes signed 5-bit direction offsets (+8..-7) into a 4-bit orientation bin and 8-bit table
// address through a 2-stage valid/ready pipeline with framing. Optional error counter: DIR_ENC_ERR_CNT_EN.
module dir_offset_encoder #(
  parameter int         FRAME_LEN = 16,
  parameter logic [3:0] ADDR_LO   = 4'h0,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_off,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_idx,
  output logic [7:0]       out_addr,
  output logic             out_err,
  output logic             out_last,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

  // Handshake: a beat moves on a side when valid && ready are both high at the rising edge.
  // The two stages advance together, so upstream sees ready whenever S2 is empty or draining.
  logic          adv;
  logic          acc;
  logic          in_ill;
  logic          in_last;
  logic [CW-1:0] beat_cnt;
  logic          sticky;

  logic          s1_full;
  logic [3:0]    s1_off_lo;
  logic          s1_ill;
  logic          s1_last;
  logic          s1_ferr;

  logic          s2_full;
  logic [3:0]    s2_idx;
  logic          s2_err;
  logic          s2_last;
  logic          s2_ferr;

  assign adv      = !s2_full || out_ready;
  assign in_ready = adv;
  assign acc      = in_valid && adv;

  // Legal offsets are 0..8 (positive) and -7..-1 (low nibble 9..F), i.e. 8 - off lands in 0..15.
  assign in_ill  = in_off[4] ? (in_off[3:0] < 4'h9) : (in_off[3:0] > 4'h8);
  assign in_last = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      sticky   <= 1'b0;
    end else if (acc) begin
      beat_cnt <= in_last ? '0 : beat_cnt + 1'b1;
      sticky   <= in_last ? 1'b0 : (sticky | in_ill);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full   <= 1'b0;
      s1_off_lo <= 4'h0;
      s1_ill    <= 1'b0;
      s1_last   <= 1'b0;
      s1_ferr   <= 1'b0;
    end else if (adv) begin
      s1_full <= in_valid;
      if (in_valid) begin
        s1_off_lo <= in_off[3:0];
        s1_ill    <= in_ill;
        s1_last   <= in_last;
        s1_ferr   <= in_last && (sticky || in_ill);
      end
    end
  end

  // Low nibble of 8 - off equals 8 - off[3:0] modulo 16; illegal beats report bin 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_full <= 1'b0;
      s2_idx  <= 4'h0;
      s2_err  <= 1'b0;
      s2_last <= 1'b0;
      s2_ferr <= 1'b0;
    end else if (adv) begin
      s2_full <= s1_full;
      if (s1_full) begin
        s2_idx  <= s1_ill ? 4'h0 : (4'h8 - s1_off_lo);
        s2_err  <= s1_ill;
        s2_last <= s1_last;
        s2_ferr <= s1_ferr;
      end
    end
  end

  assign out_valid = s2_full;
  assign out_idx   = s2_idx;
  assign out_addr  = {s2_idx, ADDR_LO};
  assign out_err   = s2_err;
  assign out_last  = s2_last;
  assign frame_err = s2_ferr;

`ifdef DIR_ENC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (s2_full && out_ready && s2_err && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_dir_offset_encoder.sv
// Scoreboard bench for dir_offset_encoder: randomized offsets, reference model from the offset rules,
// decoupled monitor comparing every output beat against an expected queue.
module tb_dir_offset_encoder;

  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_off;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_idx;
  logic [7:0]       out_addr;
  logic             out_err;
  logic             out_last;
  logic             frame_err;
  logic [CNT_W-1:0] err_cnt;

  dir_offset_encoder #(.FRAME_LEN(FRAME_LEN), .ADDR_LO(4'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_off(in_off),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_addr(out_addr), .out_err(out_err),
    .out_last(out_last), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // packing: [3:0] idx, [11:4] addr, [12] err, [13] last, [14] frame_err, [46:15] accept cycle
  logic [46:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int beat_no = 0;
  bit frame_bad = 0;
  int ecnt_exp = 0;
  bit lat_chk = 0;
  bit rand_rdy = 0;
  bit hold_v = 0;
  logic [14:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bin = 8 - offset as plain integers; legal bins are 0..15.
  task automatic push_expected(input logic [4:0] off);
    int v, b;
    bit ill, last, ferr;
    logic [3:0] idx;
    v = $signed(off);
    b = 8 - v;
    ill = (b < 0) || (b > 15);
    idx = ill ? 4'h0 : 4'(b);
    last = (beat_no % FRAME_LEN) == FRAME_LEN - 1;
    frame_bad = frame_bad | ill;
    ferr = last && frame_bad;
    if (last) frame_bad = 0;
    beat_no++;
    exp_q.push_back({32'(cyc), ferr, last, ill, idx, 4'h0, idx});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [4:0] off);
    int t;
    in_valid = 1'b1;
    in_off   = off;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    else push_expected(off);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    beat_no = 0;
    frame_bad = 0;
    ecnt_exp = 0;
    hold_v = 0;
    idle(3);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk({name, "_drain_left"}, 64'(exp_q.size()), 0);
    idle(2);
    chk({name, "_err_cnt"}, 64'(err_cnt), 64'(ecnt_exp));
  endtask

  function automatic logic [4:0] rand_legal();
    int b;
    b = $urandom_range(0, 15);
    return 5'(8 - b);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        hold_v = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          logic [46:0] e;
          e = exp_q.pop_front();
          chk("out_idx", 64'(out_idx), 64'(e[3:0]));
          chk("out_addr", 64'(out_addr), 64'(e[11:4]));
          chk("out_err", 64'(out_err), 64'(e[12]));
          chk("out_last", 64'(out_last), 64'(e[13]));
          chk("frame_err", 64'(frame_err), 64'(e[14]));
          if (lat_chk) chk("latency", 64'(cyc - int'(e[46:15])), 2);
`ifdef DIR_ENC_ERR_CNT_EN
          if (e[12] && ecnt_exp < (1 << CNT_W) - 1) ecnt_exp++;
`endif
        end
      end else if (out_valid) begin
        if (hold_v)
          chk("stall_hold", 64'({out_idx, out_addr, out_err, out_last, frame_err}), 64'(held));
        held   = {out_idx, out_addr, out_err, out_last, frame_err};
        hold_v = 1;
      end else begin
        hold_v = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] sweep;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_off = 5'h00;
    out_ready = 1'b1;
    idle(3);
    rst_n = 1'b1;
    #1;

    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_idx", 64'(out_idx), 0);
    chk("rst_out_addr", 64'(out_addr), 0);
    chk("rst_flags", 64'({out_err, out_last, frame_err}), 0);
    chk("rst_err_cnt", 64'(err_cnt), 0);
    chk("rst_in_ready", 64'(in_ready), 1);

    // 1: full legal sweep, bins 0..15 in order with 2-cycle latency
    lat_chk = 1;
    sweep = 5'h08;
    for (int i = 0; i < 16; i++) begin
      send(sweep);
      sweep = sweep - 5'd1;
    end
    drain("sweep");
    lat_chk = 0;

    // 2: boundary illegal offsets
    send(5'h09);
    send(5'h18);
    drain("illegal");

    // 3: framing with one bad beat, then a clean frame (frame realigned by reset)
    do_reset();
    for (int i = 0; i < 16; i++) send(i == 5 ? 5'h10 : rand_legal());
    for (int i = 0; i < 16; i++) send(rand_legal());
    drain("frame");

    // 4: 5-cycle output stall in the middle of a continuous stream
    fork
      for (int i = 0; i < 24; i++) send(rand_legal());
      begin
        idle(6);
        out_ready = 1'b0;
        idle(4);
        @(negedge clk);
        chk("stall_in_ready", 64'(in_ready), 0);
        chk("stall_out_valid", 64'(out_valid), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("stall");

    // 5: reset at beat 7 with two beats in flight
    do_reset();
    for (int i = 0; i < 7; i++) send(rand_legal());
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 0);
    exp_q.delete();
    beat_no = 0;
    frame_bad = 0;
    ecnt_exp = 0;
    idle(2);
    rst_n = 1'b1;
    #1;
    idle(3);
    chk("midrst_no_output", 64'(out_valid), 0);
    for (int i = 0; i < 16; i++) send(rand_legal());
    drain("midrst");

    // random offsets over the whole 5-bit range with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 80; i++) begin
      send(5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain("random");

    // 6: counter saturation
    for (int i = 0; i < 20; i++) send(($urandom_range(0, 1) != 0) ? 5'h09 : 5'h18);
    drain("saturate");
`ifdef DIR_ENC_ERR_CNT_EN
    chk("err_cnt_sat", 64'(err_cnt), 64'((1 << CNT_W) - 1));
`else
    chk("err_cnt_tied", 64'(err_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
